channel_read_arbiter: RTL and testbench

- Shares one ac_channel read side between two consumer kernels, e.g. two reduce kernels draining a common input channel.
- Grants the channel to one requester at a time, round-robin, for a burst of BURST pops or until the owner drops its request.
- Consumers use the normal channel read handshake unchanged; the arbiter routes ready/valid and gates non-owners.

---
 rtl/channel_read_arbiter.sv | 109 ++++++++++
 tb/tb_channel_read_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/channel_read_arbiter.sv
// Round-robin arbiter that lets two consumers share the read side of one channel.
// The owner gets bursts of up to BURST pops; non-owners are held off.
module channel_read_arbiter #(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ch_read_valid,
  input  logic             ch_read_ready,
  input  logic [WIDTH-1:0] ch_out_data,
  input  logic             rq0_req,
  input  logic             rq0_read_valid,
  output logic             rq0_read_ready,
  output logic [WIDTH-1:0] rq0_out_data,
  input  logic             rq1_req,
  input  logic             rq1_read_valid,
  output logic             rq1_read_ready,
  output logic [WIDTH-1:0] rq1_out_data,
  output logic [1:0]       grant,
  output logic             burst_done
);

  localparam logic [15:0] BURST_LIMIT = 16'(BURST);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] count_q, count_d;
  logic        last_owner_q, last_owner_d;
  logic        burst_done_q, burst_done_d;

  logic owner;
  logic owner_req;
  logic pop;

  // grant_q is only non-zero in OWN, so it alone gates the handshake.
  always_comb begin
    owner          = grant_q[1];
    owner_req      = owner ? rq1_req : rq0_req;
    rq0_read_ready = grant_q[0] & ch_read_ready;
    rq1_read_ready = grant_q[1] & ch_read_ready;
    ch_read_valid  = (grant_q[0] & rq0_read_valid) | (grant_q[1] & rq1_read_valid);
    pop            = ch_read_valid & ch_read_ready;
    rq0_out_data   = ch_out_data;
    rq1_out_data   = ch_out_data;
    grant          = grant_q;
    burst_done     = burst_done_q;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    count_d      = count_q;
    last_owner_d = last_owner_q;
    burst_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rq0_req && rq1_req) begin
          state_d = OWN;
          grant_d = last_owner_q ? 2'b01 : 2'b10;
        end else if (rq0_req) begin
          state_d = OWN;
          grant_d = 2'b01;
        end else if (rq1_req) begin
          state_d = OWN;
          grant_d = 2'b10;
        end
      end
      OWN: begin
        count_d = count_q + {15'd0, pop};
        // A pop in the same cycle as a dropped request is still taken before release.
        if ((pop && (count_d == BURST_LIMIT)) || !owner_req) begin
          state_d      = IDLE;
          grant_d      = 2'b00;
          count_d      = 16'd0;
          last_owner_d = owner;
          burst_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
        count_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      count_q      <= 16'd0;
      last_owner_q <= 1'b1;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      count_q      <= count_d;
      last_owner_q <= last_owner_d;
      burst_done_q <= burst_done_d;
    end
  end

endmodule

// File: tb/tb_channel_read_arbiter.sv
// Directed bench for channel_read_arbiter: a per-cycle vector table followed by
// hand-written contention, early-release and mid-burst reset sequences.
module tb_channel_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ch_read_valid;
  logic        ch_read_ready;
  logic [31:0] ch_out_data;
  logic        rq0_req, rq0_read_valid, rq0_read_ready;
  logic [31:0] rq0_out_data;
  logic        rq1_req, rq1_read_valid, rq1_read_ready;
  logic [31:0] rq1_out_data;
  logic [1:0]  grant;
  logic        burst_done;

  int checks_total  = 0;
  int checks_passed = 0;
  int pop_count     = 0;

  channel_read_arbiter #(.WIDTH(32), .BURST(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ch_read_valid  (ch_read_valid),
    .ch_read_ready  (ch_read_ready),
    .ch_out_data    (ch_out_data),
    .rq0_req        (rq0_req),
    .rq0_read_valid (rq0_read_valid),
    .rq0_read_ready (rq0_read_ready),
    .rq0_out_data   (rq0_out_data),
    .rq1_req        (rq1_req),
    .rq1_read_valid (rq1_read_valid),
    .rq1_read_ready (rq1_read_ready),
    .rq1_out_data   (rq1_out_data),
    .grant          (grant),
    .burst_done     (burst_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0q, r0v, r1q, r1v, chr;
    logic [31:0] chd;
    logic [1:0]  g;
    logic        bd, cv, r0r, r1r;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic r0q, logic r0v, logic r1q, logic r1v, logic chr,
                              logic [31:0] chd, logic [1:0] g, logic bd, logic cv,
                              logic r0r, logic r1r);
    vec_t v;
    v.r0q = r0q; v.r0v = r0v; v.r1q = r1q; v.r1v = r1v; v.chr = chr; v.chd = chd;
    v.g = g; v.bd = bd; v.cv = cv; v.r0r = r0r; v.r1r = r1r;
    return v;
  endfunction

  // Drives one cycle's inputs just after the falling edge, then lets outputs settle.
  task automatic applyStimulus(input logic r, input logic r0q, input logic r0v,
                               input logic r1q, input logic r1v, input logic chr,
                               input logic [31:0] chd);
    @(negedge clk);
    rst            = r;
    rq0_req        = r0q;
    rq0_read_valid = r0v;
    rq1_req        = r1q;
    rq1_read_valid = r1v;
    ch_read_ready  = chr;
    ch_out_data    = chd;
    #1;
    if (ch_read_valid && ch_read_ready) pop_count++;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, actual, expected);
    else
      checks_passed++;
  endtask

  task automatic stepCheck(input string tag, input int idx, input logic r,
                           input logic r0q, input logic r0v, input logic r1q,
                           input logic r1v, input logic chr, input logic [1:0] eg,
                           input logic ebd, input logic ecv);
    applyStimulus(r, r0q, r0v, r1q, r1v, chr, 32'd0);
    checkOutput({tag, "_grant"}, idx, 32'(grant), 32'(eg));
    checkOutput({tag, "_burst_done"}, idx, 32'(burst_done), 32'(ebd));
    checkOutput({tag, "_ch_read_valid"}, idx, 32'(ch_read_valid), 32'(ecv));
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [1:0] cont_g[16];
    rst = 1'b1; rq0_req = 1'b0; rq0_read_valid = 1'b0; rq1_req = 1'b0;
    rq1_read_valid = 1'b0; ch_read_ready = 1'b0; ch_out_data = 32'd0;

    // Single requester: pops carry 10,20,30,40 into the following cycle.
    vecs[0]  = mk(1,0,0,0,1, 32'd0,  2'b00, 0,0,0,0);
    vecs[1]  = mk(1,1,0,0,1, 32'd0,  2'b01, 0,1,1,0);
    vecs[2]  = mk(1,1,0,0,1, 32'd10, 2'b01, 0,1,1,0);
    vecs[3]  = mk(1,1,0,0,1, 32'd20, 2'b01, 0,1,1,0);
    vecs[4]  = mk(1,1,0,0,1, 32'd30, 2'b01, 0,1,1,0);
    vecs[5]  = mk(0,0,0,0,1, 32'd40, 2'b00, 1,0,0,0);
    // Stall: three not-ready cycles must not count toward the burst.
    vecs[6]  = mk(1,0,0,0,0, 32'd5,  2'b00, 0,0,0,0);
    vecs[7]  = mk(1,1,0,0,0, 32'd6,  2'b01, 0,1,0,0);
    vecs[8]  = mk(1,1,0,0,0, 32'd7,  2'b01, 0,1,0,0);
    vecs[9]  = mk(1,1,0,0,0, 32'd8,  2'b01, 0,1,0,0);
    vecs[10] = mk(1,1,0,0,1, 32'd9,  2'b01, 0,1,1,0);
    vecs[11] = mk(1,1,0,0,1, 32'd11, 2'b01, 0,1,1,0);
    vecs[12] = mk(1,1,0,0,1, 32'd12, 2'b01, 0,1,1,0);
    vecs[13] = mk(1,1,0,0,1, 32'd13, 2'b01, 0,1,1,0);
    vecs[14] = mk(0,0,0,0,1, 32'd14, 2'b00, 1,0,0,0);
    // Isolation: rq1 strobes throughout but never reaches the channel.
    vecs[15] = mk(1,0,0,1,1, 32'd15, 2'b00, 0,0,0,0);
    vecs[16] = mk(1,0,0,1,1, 32'd16, 2'b01, 0,0,1,0);
    vecs[17] = mk(1,1,0,1,1, 32'd17, 2'b01, 0,1,1,0);
    vecs[18] = mk(1,0,0,1,1, 32'd18, 2'b01, 0,0,1,0);
    vecs[19] = mk(1,1,0,1,1, 32'd19, 2'b01, 0,1,1,0);
    vecs[20] = mk(1,1,0,1,1, 32'd20, 2'b01, 0,1,1,0);
    vecs[21] = mk(1,0,0,1,1, 32'd21, 2'b01, 0,0,1,0);
    vecs[22] = mk(1,1,0,1,1, 32'd22, 2'b01, 0,1,1,0);
    vecs[23] = mk(0,0,0,1,1, 32'd23, 2'b00, 1,0,0,0);

    cont_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
               2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};

    doReset();
    checkOutput("reset_grant", 0, 32'(grant), 32'd0);
    checkOutput("reset_burst_done", 0, 32'(burst_done), 32'd0);
    checkOutput("reset_ch_read_valid", 0, 32'(ch_read_valid), 32'd0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b0, vecs[i].r0q, vecs[i].r0v, vecs[i].r1q, vecs[i].r1v,
                    vecs[i].chr, vecs[i].chd);
      checkOutput("vec_grant", i, 32'(grant), 32'(vecs[i].g));
      checkOutput("vec_burst_done", i, 32'(burst_done), 32'(vecs[i].bd));
      checkOutput("vec_ch_read_valid", i, 32'(ch_read_valid), 32'(vecs[i].cv));
      checkOutput("vec_rq0_read_ready", i, 32'(rq0_read_ready), 32'(vecs[i].r0r));
      checkOutput("vec_rq1_read_ready", i, 32'(rq1_read_ready), 32'(vecs[i].r1r));
      checkOutput("vec_rq0_out_data", i, rq0_out_data, vecs[i].chd);
      checkOutput("vec_rq1_out_data", i, rq1_out_data, vecs[i].chd);
    end

    // Continuous contention after reset: rq0 first, then strict alternation.
    doReset();
    pop_count = 0;
    for (int c = 0; c < 16; c++) begin
      stepCheck("contend", c, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, cont_g[c],
                (c == 5 || c == 10 || c == 15), (cont_g[c] != 2'b00));
    end
    checkOutput("contend_pops", 0, 32'(pop_count), 32'd12);

    // rq1 owns, drops its request after two pops; rq0 takes over after one idle cycle.
    stepCheck("early", 0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
    stepCheck("early", 1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
    stepCheck("early", 2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    stepCheck("early", 3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    stepCheck("early", 4,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    stepCheck("early", 5,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    stepCheck("early", 6,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    stepCheck("early", 7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    stepCheck("early", 8,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);

    // rq1 is mid-burst with rq0 as last owner; reset must abort and restore rq0 priority.
    stepCheck("rstmid", 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
    stepCheck("rstmid", 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
    stepCheck("rstmid", 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
    stepCheck("rstmid", 3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    stepCheck("rstmid", 4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    stepCheck("rstmid", 5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    stepCheck("rstmid", 6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    stepCheck("rstmid", 7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    stepCheck("rstmid", 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
